// File: rtl/divider_32_bit_seq.sv
// Sequential unsigned restoring divider that yields one quotient bit per clock.
// Start/Busy/Done handshake. A zero divisor skips the iteration and reports an all-ones quotient.
module divider_32_bit_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Dividend_In,
  input  logic [DATA_WIDTH-1:0] Divisor_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Quotient_Out,
  output logic [DATA_WIDTH-1:0] Remainder_Out,
  output logic                  Div_By_Zero_Out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [CNT_W-1:0]        count_reg;
  logic [DATA_WIDTH-1:0]   rem_reg;
  logic [DATA_WIDTH-1:0]   quo_reg;
  logic [DATA_WIDTH-1:0]   divisor_reg;
  logic [DATA_WIDTH-1:0]   quotient_reg;
  logic [DATA_WIDTH-1:0]   remainder_reg;
  logic                    dbz_reg;

  logic                    start_accept;
  logic                    divisor_zero;
  logic                    last_iter;

  logic [DATA_WIDTH:0]     shifted;
  logic [DATA_WIDTH:0]     diff;
  logic                    trial_ok;
  logic [DATA_WIDTH-1:0]   rem_step;
  logic [DATA_WIDTH-1:0]   quo_step;

  assign start_accept = (state_reg == ST_IDLE) && Start_In;
  assign divisor_zero = (Divisor_In == '0);
  assign last_iter    = (state_reg == ST_RUN) && (count_reg == LAST_ITER);

  // One restoring step. The shifted remainder is DATA_WIDTH+1 bits wide. Its top bit set
  // means it already exceeds any divisor, so the subtract always succeeds in that case.
  // The low-word difference is then the correct result modulo 2^DATA_WIDTH.
  always_comb begin
    shifted  = {rem_reg, quo_reg[DATA_WIDTH-1]};
    diff     = {1'b0, shifted[DATA_WIDTH-1:0]} - {1'b0, divisor_reg};
    trial_ok = shifted[DATA_WIDTH] | ~diff[DATA_WIDTH];
    rem_step = trial_ok ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_step = {quo_reg[DATA_WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (Start_In) begin
          state_next = divisor_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy_Out = 1'b0;
    Done_Out = 1'b0;
    case (state_reg)
      ST_RUN:  Busy_Out = 1'b1;
      ST_DONE: begin
        Busy_Out = 1'b1;
        Done_Out = 1'b1;
      end
      default: ;
    endcase
  end

  // Working registers and the result registers. The result registers move only on an
  // accepted start (zero-divisor path), on the last iteration, or on reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (start_accept) begin
      divisor_reg <= Divisor_In;
      count_reg   <= '0;
      if (divisor_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= Dividend_In;
        dbz_reg       <= 1'b1;
      end else begin
        rem_reg <= '0;
        quo_reg <= Dividend_In;
        dbz_reg <= 1'b0;
      end
    end else if (state_reg == ST_RUN) begin
      rem_reg   <= rem_step;
      quo_reg   <= quo_step;
      count_reg <= count_reg + 1'b1;
      if (last_iter) begin
        quotient_reg  <= quo_step;
        remainder_reg <= rem_step;
      end
    end
  end

  assign Quotient_Out    = quotient_reg;
  assign Remainder_Out   = remainder_reg;
  assign Div_By_Zero_Out = dbz_reg;

endmodule
